// File: rtl/apu_uart_tx.sv
// apu_uart_tx: serializes APU register writes into two 8N1 UART frames.
// Frame 0 = {addr, 0, data[3:0]}, frame 1 = {addr, 1, data[7:4]}, LSB first.
// Optional build macro: APU_UART_TX_TWO_STOP_EN (two stop bits per frame).
module apu_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef APU_UART_TX_TWO_STOP_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          nib_q, nib_d;
  logic [2:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          tx_d, busy_d, ready_d;
  logic [7:0]    frame_c;
  logic          baud_end_c;

  // Byte currently on the wire, selected by the nibble flag.
  assign frame_c    = {addr_q, nib_q, (nib_q ? data_q[7:4] : data_q[3:0])};
  assign baud_end_c = (baud_q == BAUD_LAST);

  // Next-state and next-output logic; tx/busy/wr_ready are precomputed here and registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    nib_d   = nib_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tx_d    = tx;
    busy_d  = busy;
    ready_d = wr_ready;

    case (state_q)
      S_IDLE: begin
        if (wr_valid && wr_ready) begin
          addr_d  = wr_addr;
          data_d  = wr_data;
          nib_d   = 1'b0;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = frame_c[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = frame_c[3'(bit_q + 3'd1)];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 3'd1;
          end else begin
            bit_d = 3'd0;
            if (!nib_q) begin
              // High-nibble frame follows with no idle gap.
              nib_d   = 1'b1;
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              nib_d   = 1'b0;
              busy_d  = 1'b0;
              ready_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces the line idle and drops any latched write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      nib_q    <= 1'b0;
      addr_q   <= 3'd0;
      data_q   <= 8'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      nib_q    <= nib_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tx       <= tx_d;
      busy     <= busy_d;
      wr_ready <= ready_d;
    end
  end

endmodule
